// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// Widths here are only the defaults; the top re-parameterises them.
package seq_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_det_shift.sv
// History shift register, fill counter and pattern comparator.
// hit is combinational on the bit being sampled this cycle.
module seq_det_shift
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             sbit,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_nxt;
  logic [FW-1:0]    fill_q;
  logic [FW-1:0]    fill_nxt;

  assign hist_nxt = {hist_q[PAT_W-2:0], sbit};
  assign fill_nxt = (fill_q == FULL) ? FULL : fill_q + FW'(1);
  assign hit = shift_en && (fill_nxt == FULL) && (hist_nxt == pattern);

  // Non-overlap restarts the fill so the next match needs fresh bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= hist_nxt;
      fill_q <= (hit && !overlap) ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run controller: config handshake, IDLE/RUN/DONE sequencing,
// saturating match counter and threshold completion.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int             PAT_W   = DEF_PAT_W,
  parameter int             CNT_W   = DEF_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PAT = DEF_PATTERN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             abort,
  input  logic             i_valid,
  input  logic             i,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             match_q;
  logic             cfg_fire;
  logic             run;
  logic             go;
  logic             stop;
  logic             hit;

  assign run       = (state_q == RUN);
  assign cfg_ready = !run;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign go        = start && !run;
  assign stop      = abort && run;
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  seq_det_shift #(
    .PAT_W(PAT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .shift_en(run && i_valid),
    .clear   (go || stop),
    .sbit    (i),
    .pattern (pat_q),
    .overlap (ovl_q),
    .hit     (hit)
  );

  // Abort takes priority over reaching the threshold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (abort)
          state_d = IDLE;
        else if (hit && thr_q != '0 && cnt_inc == thr_q)
          state_d = DONE;
      end
      DONE: begin
        if (start)
          state_d = RUN;
        else if (cfg_fire)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= DEF_PAT;
      ovl_q   <= 1'b1;
      thr_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= hit;
      if (cfg_fire) begin
        pat_q <= cfg_pattern;
        ovl_q <= cfg_overlap;
        thr_q <= cfg_thresh;
      end
      if (go)
        cnt_q <= '0;
      else if (hit)
        cnt_q <= cnt_inc;
    end
  end

  assign busy      = run;
  assign done      = (state_q == DONE);
  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule
